// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side bundle of a UART receiver.
//   RX        serial line, idle high, asynchronous to the core clock
//   rx_ready  consumer accepts rx_data when rx_valid & rx_ready
//   rx_data   received byte, LSB = first data bit on the line
//   rx_valid  rx_data holds an unconsumed byte
//   frame_err 1-cycle pulse: stop bit sampled low
//   overrun   1-cycle pulse: new byte dropped, holding register full
//   busy      receiver is inside a frame
// master drives the line and consumes bytes; slave is the receiver.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 RX;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;
    modport master (output RX, rx_ready, input rx_data, rx_valid, frame_err, overrun, busy);
    modport slave (input RX, rx_ready, output rx_data, rx_valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with a valid/ready holding register.
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_rx_if.slave: RX in, rx_ready in; rx_data, rx_valid, frame_err, overrun, busy out
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (CPB < 4) begin : g_cpb_chk
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s, rx_d;
    logic [CW-1:0]        clk_cnt, clk_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                 valid_n, ferr_n, ovr_n;

    assign bus.busy = (state != IDLE);

    // rx_m/rx_s synchronise the line; rx_d is one more stage for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            rx_d          <= 1'b1;
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            rx_m          <= bus.RX;
            rx_s          <= rx_m;
            rx_d          <= rx_s;
            state         <= state_n;
            clk_cnt       <= clk_cnt_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            bus.rx_data   <= data_n;
            bus.rx_valid  <= valid_n;
            bus.frame_err <= ferr_n;
            bus.overrun   <= ovr_n;
        end
    end

    // A byte loaded on the same edge a consumer takes the old one wins: valid stays set.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + 1'b1;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        data_n    = bus.rx_data;
        valid_n   = bus.rx_valid & ~bus.rx_ready;
        ferr_n    = 1'b0;
        ovr_n     = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                if (rx_d && !rx_s) state_n = START;
            end
            START: if (clk_cnt == HALF_END) begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                state_n   = rx_s ? IDLE : DATA;
            end
            DATA: if (clk_cnt == BIT_END) begin
                clk_cnt_n = '0;
                shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) state_n = STOP;
            end
            STOP: if (clk_cnt == BIT_END) begin
                clk_cnt_n = '0;
                state_n   = IDLE;
                if (!rx_s) ferr_n = 1'b1;
                else if (!bus.rx_valid || bus.rx_ready) begin
                    data_n  = shreg;
                    valid_n = 1'b1;
                end else ovr_n = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (10 clk/bit instance and default 434 clk/bit instance).
module tb_uart_rx;
    typedef struct {
        int         dut;
        int         kind;
        logic [7:0] data;
    } exp_t;

    localparam int K_BYTE = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   vcount = 0;
    exp_t sb[$];
    logic pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;

    always #10 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) b0 ();
    uart_rx_if #(.DATA_BITS(8)) b1 ();

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8)) u_fast (
        .clk(clk), .rst(rst), .bus(b0)
    );
    uart_rx u_dflt (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int dut, input int kind, input logic [7:0] d);
        exp_t e;
        e.dut  = dut;
        e.kind = kind;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic got(input int dut, input int kind, input logic [7:0] d);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: dut%0d kind %0d data %02h, required no event", dut, kind, d);
        end else begin
            e = sb.pop_front();
            if (e.dut != dut || e.kind != kind || e.data !== d) begin
                errors++;
                $display("FAIL sb_event: dut%0d kind %0d data %02h, required dut%0d kind %0d data %02h",
                         dut, kind, d, e.dut, e.kind, e.data);
            end
        end
    endtask

    task automatic observe(input int dut, input logic v, input logic pv, input logic pr,
                           input logic fe, input logic ov, input logic [7:0] d);
        if (fe || ov) chk("flag_exclusive", {31'd0, fe & ov}, 32'd0);
        if (v && (!pv || pr)) got(dut, K_BYTE, d);
        if (fe) got(dut, K_FERR, 8'h00);
        if (ov) got(dut, K_OVR, 8'h00);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pv0 = 1'b0; pr0 = 1'b0; pv1 = 1'b0; pr1 = 1'b0;
        end else begin
            observe(0, b0.rx_valid, pv0, pr0, b0.frame_err, b0.overrun, b0.rx_data);
            observe(1, b1.rx_valid, pv1, pr1, b1.frame_err, b1.overrun, b1.rx_data);
            if (b0.rx_valid) vcount++;
            pv0 = b0.rx_valid; pr0 = b0.rx_ready;
            pv1 = b1.rx_valid; pr1 = b1.rx_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int dut, input logic v);
        if (dut == 1) b1.RX = v;
        else b0.RX = v;
    endtask

    task automatic send(input int dut, input logic [7:0] d, input logic stop, input int cpb);
        set_rx(dut, 1'b0);
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            set_rx(dut, d[i]);
            tick(cpb);
        end
        set_rx(dut, stop);
        tick(cpb);
        set_rx(dut, 1'b1);
    endtask

    task automatic outputs_zero(input string name);
        chk({name, "_data"}, {24'd0, b0.rx_data}, 32'd0);
        chk({name, "_ctl"}, {28'd0, b0.rx_valid, b0.frame_err, b0.overrun, b0.busy}, 32'd0);
    endtask

    initial begin
        b0.RX = 1'b1; b0.rx_ready = 1'b0;
        b1.RX = 1'b1; b1.rx_ready = 1'b0;
        tick(3);
        outputs_zero("reset");
        chk("reset_dflt_ctl", {28'd0, b1.rx_valid, b1.frame_err, b1.overrun, b1.busy}, 32'd0);
        rst = 1'b0;
        tick(5);

        // single frame, always ready: valid exactly one cycle
        b0.rx_ready = 1'b1;
        vcount = 0;
        push(0, K_BYTE, 8'h55);
        send(0, 8'h55, 1'b1, 10);
        tick(20);
        chk("t1_valid_cycles", vcount, 1);
        chk("t1_busy", {31'd0, b0.busy}, 0);
        chk("t1_drain", sb.size(), 0);

        // back-to-back frames, no consumer: second byte overruns
        b0.rx_ready = 1'b0;
        push(0, K_BYTE, 8'hA3);
        push(0, K_OVR, 8'h00);
        send(0, 8'hA3, 1'b1, 10);
        send(0, 8'h3C, 1'b1, 10);
        tick(20);
        chk("t2_data_held", {24'd0, b0.rx_data}, 32'hA3);
        chk("t2_valid_held", {31'd0, b0.rx_valid}, 1);
        b0.rx_ready = 1'b1;
        tick(1);
        b0.rx_ready = 1'b0;
        chk("t2_consumed", {31'd0, b0.rx_valid}, 0);
        chk("t2_drain", sb.size(), 0);

        // short low glitch rejected in START
        b0.rx_ready = 1'b1;
        vcount = 0;
        set_rx(0, 1'b0);
        tick(3);
        chk("t3_busy_rise", {31'd0, b0.busy}, 1);
        set_rx(0, 1'b1);
        for (int i = 0; i < 8 && b0.busy; i++) tick(1);
        chk("t3_busy_fall", {31'd0, b0.busy}, 0);
        tick(20);
        chk("t3_no_valid", vcount, 0);

        // bad stop bit, then a good frame
        push(0, K_FERR, 8'h00);
        send(0, 8'h0F, 1'b0, 10);
        tick(20);
        chk("t4_no_valid", vcount, 0);
        chk("t4_ferr_drain", sb.size(), 0);
        push(0, K_BYTE, 8'h81);
        send(0, 8'h81, 1'b1, 10);
        tick(20);
        chk("t4_drain", sb.size(), 0);

        // reset part way through a frame
        set_rx(0, 1'b0);
        tick(10);
        for (int i = 0; i < 4; i++) begin
            set_rx(0, (i == 1 || i == 2) ? 1'b1 : 1'b0);
            tick(10);
        end
        rst = 1'b1;
        tick(2);
        outputs_zero("t5_in_reset");
        set_rx(0, 1'b1);
        tick(2);
        rst = 1'b0;
        tick(5);
        push(0, K_BYTE, 8'h81);
        send(0, 8'h81, 1'b1, 10);
        tick(20);
        chk("t5_data", {24'd0, b0.rx_data}, 32'h81);
        chk("t5_drain", sb.size(), 0);

        // default 434 clk/bit instance, line +3% and -3% off nominal
        b1.rx_ready = 1'b1;
        push(1, K_BYTE, 8'hF0);
        send(1, 8'hF0, 1'b1, 447);
        tick(500);
        push(1, K_BYTE, 8'hF0);
        send(1, 8'hF0, 1'b1, 421);
        tick(500);
        chk("t6_drain", sb.size(), 0);
        chk("t6_busy", {31'd0, b1.busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
